// File: rtl/serial_negator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_negator
//  Description : Chunk-serial ones'/two's-complement negator with valid/ready
//                handshakes and two's-complement overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_negator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    C_K_LAST   = KW'(N - 1);
    localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [KW-1:0]      r_k_q, w_k_d;
    logic               r_carry_q, w_carry_d;
    logic               r_mode_q, w_mode_d;
    logic [WIDTH-1:0]   r_op_q, w_op_d;
    logic [WIDTH-1:0]   r_res_q, w_res_d;

    int                 w_base;
    logic [CHUNK-1:0]   w_chunk;
    logic [CHUNK:0]     w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_k_q     <= '0;
            r_carry_q <= 1'b0;
            r_mode_q  <= 1'b0;
            r_op_q    <= '0;
            r_res_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_k_q     <= w_k_d;
            r_carry_q <= w_carry_d;
            r_mode_q  <= w_mode_d;
            r_op_q    <= w_op_d;
            r_res_q   <= w_res_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_k_d     = r_k_q;
        w_carry_d = r_carry_q;
        w_mode_d  = r_mode_q;
        w_op_d    = r_op_q;
        w_res_d   = r_res_q;

        w_base  = int'(r_k_q) * CHUNK;
        w_chunk = r_op_q[w_base +: CHUNK];
        w_sum   = {1'b0, ~w_chunk} + {{CHUNK{1'b0}}, r_carry_q};

        case (r_state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_op_d    = in_data;
                    w_mode_d  = in_mode;
                    w_k_d     = '0;
                    w_carry_d = in_mode;    // +1 of two's complement enters as carry-in
                    w_res_d   = '0;
                    w_state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                w_res_d[w_base +: CHUNK] = w_sum[CHUNK-1:0];
                w_carry_d                = w_sum[CHUNK];
                if (r_k_q == C_K_LAST) begin
                    w_k_d     = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_k_d = r_k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state_q == S_IDLE);
    assign out_valid = (r_state_q == S_DONE);
    assign out_data  = out_valid ? r_res_q : '0;
    assign out_ovf   = out_valid & r_mode_q & (r_op_q == C_MOST_NEG);

endmodule
`default_nettype wire
